// File: rtl/main_memory_arbiter_pkg.sv
// rtl/main_memory_arbiter_pkg.sv - shared types and constants for the main-memory arbiter
package main_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  localparam int DEFAULT_DATAWIDTH_BUS  = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Timeout counter is never narrower than 8 bits.
  function automatic int tmo_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/main_memory_arbiter_rr_grant_pointer.sv
// rtl/main_memory_arbiter_rr_grant_pointer.sv - two-port round-robin winner select
// last_grant starts at PORT_DATA so the first tie goes to PORT_IFETCH.
module rr_grant_pointer
  import main_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       winner,
  output logic       valid
);

  logic last_grant;

  always_comb begin
    valid  = |req;
    winner = PORT_IFETCH;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = PORT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_DATA;
    end else if (grant_en && valid) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// rtl/main_memory_arbiter.sv - round-robin arbiter sharing one main-memory port between fetch and data
// Optional BUSY timeout abort enabled by defining MAIN_MEMORY_ARBITER_TIMEOUT_EN.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DEFAULT_DATAWIDTH_BUS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     MAIN_MEMORY_ARBITER_CLOCK_50,
  input  logic                     MAIN_MEMORY_ARBITER_ResetInHigh_In,
  input  logic                     MAIN_MEMORY_ARBITER_REQ0_Req_In,
  input  logic                     MAIN_MEMORY_ARBITER_REQ1_Req_In,
  input  logic                     MAIN_MEMORY_ARBITER_REQ0_Wr_In,
  input  logic                     MAIN_MEMORY_ARBITER_REQ1_Wr_In,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ0_Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ1_Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ0_Data_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ1_Data_InBus,
  output logic                     MAIN_MEMORY_ARBITER_REQ0_Ack_Out,
  output logic                     MAIN_MEMORY_ARBITER_REQ1_Ack_Out,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ0_Data_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_REQ1_Data_OutBus,
  output logic                     MAIN_MEMORY_ARBITER_Err_Out,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MEM_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MEM_B_OutBus,
  output logic                     MAIN_MEMORY_ARBITER_MEM_RD_Out,
  output logic                     MAIN_MEMORY_ARBITER_MEM_WRMain_Out,
  input  logic                     MAIN_MEMORY_ARBITER_MEM_ACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_ARBITER_MEM_Data_InBus
);

  logic clk;
  logic reset;
  logic mem_ack;

  state_t state;
  state_t next_state;

  logic grant_en;
  logic grant_winner;
  logic grant_valid;
  logic timeout_hit;

  logic                     winner_q, winner_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     err_q, err_d;
  logic [DATAWIDTH_BUS-1:0] a_q, a_d;
  logic [DATAWIDTH_BUS-1:0] b_q, b_d;
  logic [DATAWIDTH_BUS-1:0] do0_q, do0_d;
  logic [DATAWIDTH_BUS-1:0] do1_q, do1_d;

  assign clk      = MAIN_MEMORY_ARBITER_CLOCK_50;
  assign reset    = MAIN_MEMORY_ARBITER_ResetInHigh_In;
  assign mem_ack  = MAIN_MEMORY_ARBITER_MEM_ACK_In;
  assign grant_en = (state == IDLE);

  rr_grant_pointer u_rr_grant_pointer (
    .clk      (clk),
    .reset    (reset),
    .req      ({MAIN_MEMORY_ARBITER_REQ1_Req_In, MAIN_MEMORY_ARBITER_REQ0_Req_In}),
    .grant_en (grant_en),
    .winner   (grant_winner),
    .valid    (grant_valid)
  );

`ifdef MAIN_MEMORY_ARBITER_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;

  // Counter is zero on the first BUSY cycle, so expiry lands on BUSY cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset || state != BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == BUSY) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = BUSY;
      BUSY:    if (mem_ack || timeout_hit) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    winner_d = winner_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    a_d      = a_q;
    b_d      = b_q;
    do0_d    = do0_q;
    do1_d    = do1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          winner_d = grant_winner;
          if (grant_winner == PORT_DATA) begin
            a_d  = MAIN_MEMORY_ARBITER_REQ1_Addr_InBus;
            b_d  = MAIN_MEMORY_ARBITER_REQ1_Data_InBus;
            wr_d = MAIN_MEMORY_ARBITER_REQ1_Wr_In;
          end else begin
            a_d  = MAIN_MEMORY_ARBITER_REQ0_Addr_InBus;
            b_d  = MAIN_MEMORY_ARBITER_REQ0_Data_InBus;
            wr_d = MAIN_MEMORY_ARBITER_REQ0_Wr_In;
          end
          rd_d = ~wr_d;
        end
      end
      BUSY: begin
        // A real ACK takes precedence over an expiry in the same cycle.
        if (mem_ack || timeout_hit) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          err_d = ~mem_ack;
          if (winner_q == PORT_DATA) begin
            ack1_d = 1'b1;
            if (!mem_ack)  do1_d = '0;
            else if (rd_q) do1_d = MAIN_MEMORY_ARBITER_MEM_Data_InBus;
          end else begin
            ack0_d = 1'b1;
            if (!mem_ack)  do0_d = '0;
            else if (rd_q) do0_d = MAIN_MEMORY_ARBITER_MEM_Data_InBus;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winner_q <= PORT_IFETCH;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      do0_q    <= '0;
      do1_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      winner_q <= winner_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      do0_q    <= do0_d;
      do1_q    <= do1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
    end
  end

  assign MAIN_MEMORY_ARBITER_REQ0_Ack_Out     = ack0_q;
  assign MAIN_MEMORY_ARBITER_REQ1_Ack_Out     = ack1_q;
  assign MAIN_MEMORY_ARBITER_REQ0_Data_OutBus = do0_q;
  assign MAIN_MEMORY_ARBITER_REQ1_Data_OutBus = do1_q;
  assign MAIN_MEMORY_ARBITER_Err_Out          = err_q;
  assign MAIN_MEMORY_ARBITER_MEM_A_OutBus     = a_q;
  assign MAIN_MEMORY_ARBITER_MEM_B_OutBus     = b_q;
  assign MAIN_MEMORY_ARBITER_MEM_RD_Out       = rd_q;
  assign MAIN_MEMORY_ARBITER_MEM_WRMain_Out   = wr_q;

endmodule

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Shares the single main-memory port between two requesters: port 0 for instruction fetch and port 1 for data load/store.
- Arbitrates between them round-robin.
- Drives the memory address/data/RD/WRMain strobes and holds them until the memory ACK.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the microsequencer/datapath and the main memory.

Parameters:
- DATAWIDTH_BUS, 32, width of address, write-data and read-data buses.
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY before abort. Used only with MAIN_MEMORY_ARBITER_TIMEOUT_EN.

Ports:
- MAIN_MEMORY_ARBITER_CLOCK_50  in  1  single clock, rising edge.
- MAIN_MEMORY_ARBITER_ResetInHigh_In  in  1  synchronous, active-high reset.
- MAIN_MEMORY_ARBITER_REQ0_Req_In / MAIN_MEMORY_ARBITER_REQ1_Req_In  in  1  request; held high until that port's Ack.
- MAIN_MEMORY_ARBITER_REQ0_Wr_In / MAIN_MEMORY_ARBITER_REQ1_Wr_In  in  1  1 = write, 0 = read.
- MAIN_MEMORY_ARBITER_REQ0_Addr_InBus / MAIN_MEMORY_ARBITER_REQ1_Addr_InBus  in  DATAWIDTH_BUS  address.
- MAIN_MEMORY_ARBITER_REQ0_Data_InBus / MAIN_MEMORY_ARBITER_REQ1_Data_InBus  in  DATAWIDTH_BUS  write data.
- MAIN_MEMORY_ARBITER_REQ0_Ack_Out / MAIN_MEMORY_ARBITER_REQ1_Ack_Out  out  1  one-cycle completion pulse.
- MAIN_MEMORY_ARBITER_REQ0_Data_OutBus / MAIN_MEMORY_ARBITER_REQ1_Data_OutBus  out  DATAWIDTH_BUS  read data; valid with Ack, held until that port's next Ack.
- MAIN_MEMORY_ARBITER_Err_Out  out  1  timeout flag; pulses with Ack.
- MAIN_MEMORY_ARBITER_MEM_A_OutBus  out  DATAWIDTH_BUS  memory address.
- MAIN_MEMORY_ARBITER_MEM_B_OutBus  out  DATAWIDTH_BUS  memory write data.
- MAIN_MEMORY_ARBITER_MEM_RD_Out  out  1  read strobe.
- MAIN_MEMORY_ARBITER_MEM_WRMain_Out  out  1  write strobe.
- MAIN_MEMORY_ARBITER_MEM_ACK_In  in  1  memory completion.
- MAIN_MEMORY_ARBITER_MEM_Data_InBus  in  DATAWIDTH_BUS  memory read data.

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - State goes to IDLE.
  - last_grant resets to 1, so port 0 wins the first tie.
  - Reset has priority over everything, including mid-transaction: strobes drop at that same edge and no Ack is issued.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - Only Req0 high: grant 0. Only Req1 high: grant 1.
  - Both high: grant the port != last_grant.
  - On grant:
    - Latch Addr, Data and Wr of the winner into A/B.
    - Assert RD = ~Wr or WRMain = Wr.
    - Set last_grant = winner and go to BUSY.
  - Strobes are visible the cycle after Req is sampled.
- BUSY:
  - Hold A, B and the strobe constant.
  - On MEM_ACK_In = 1:
    - Drop the strobe next edge.
    - For a read, register MEM_Data_InBus into the winner's Data_OutBus; for a write, leave Data_OutBus unchanged.
    - Pulse the winner's Ack for exactly one cycle.
    - Go to RELEASE.
- RELEASE:
  - One cycle; no grant is issued. The served requester must drop or renew Req here.
  - Go to IDLE.
  - A Req still high in IDLE is treated as a new request.
- Minimum latency:
  - Req at edge n, strobe at n+1.
  - ACK sampled at n+1 gives Ack at n+2.
  - Next grant no earlier than n+3.
- Boundary cases:
  - At most one strobe is ever high.
  - The loser keeps waiting; its Req is not dropped.
  - Req falling during BUSY is ignored; the transaction completes and Ack still pulses.
  - MEM_ACK_In outside BUSY is ignored.
  - Address and data are not re-sampled after grant.

Optional Feature:
- MAIN_MEMORY_ARBITER_TIMEOUT_EN defined:
  - 8-bit+ counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without ACK:
    - Drop the strobe and pulse the winner's Ack with Err_Out = 1.
    - Data_OutBus = 0.
    - Go to RELEASE.
  - ACK arriving in the expiry cycle wins: normal completion, Err_Out = 0.
- Undefined:
  - BUSY waits indefinitely and no counter is synthesized.
  - Err_Out is tied to 0; the port always exists.

Decomposition:
- Package main_memory_arbiter_pkg holds:
  - State encoding constants (IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2).
  - Port index constants (PORT_IFETCH = 0, PORT_DATA = 1).
  - Default DATAWIDTH_BUS and TIMEOUT_CYCLES.
- One sub-module, rr_grant_pointer:
  - Registered last_grant plus the combinational winner select.
  - Inputs: req[1:0], grant_en. Outputs: winner, valid.

Test Plan:
- Read port 0: Req0 = 1, Addr = 0x10, memory ACK 2 cycles after RD with data 0xCAFE → RD high exactly 2 cycles at A = 0x10, REQ0 Ack 1 cycle, REQ0_Data_OutBus = 0xCAFE, Err_Out = 0.
- Write port 1: Req1 = 1, Wr = 1, Addr = 0x20, Data = 0x55 → WRMain high with A = 0x20, B = 0x55, RD never high, REQ1 Ack after ACK, REQ1_Data_OutBus unchanged.
- Tie after reset: both Req high continuously, ACK immediate → grant order 0, 1, 0, 1; one RELEASE cycle between transactions; never two strobes.
- Reset mid-BUSY: assert ResetInHigh during RD wait → strobes and Acks 0 the next cycle, state IDLE, later tie grants port 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): no ACK → after 4 BUSY cycles RD drops, Ack and Err_Out pulse, Data_OutBus = 0. Macro undefined: RD stays high for 1000 cycles.
- Spurious ACK in IDLE, and Req0 dropped mid-BUSY → no Ack from the spurious ACK; the dropped-Req transaction still completes with an Ack.
